// File: rtl/coh_noc_vc_input_buffer.sv
// Per-VC input buffer: NUM_VC credit-fed FIFOs, round-robin onto one valid/ready output, one credit back per pop.
// Latency: write in cycle N presentable in N+1; credit registered one cycle after pop. Grant held stable under backpressure.
// Optional COH_NOC_VCBUF_HWM_EN adds a per-VC high-water-mark output.
module coh_noc_vc_input_buffer #(
    parameter  int NUM_VC = 4,
    parameter  int DEPTH  = 16,
    parameter  int FLIT_W = 128,
    localparam int VC_W   = $clog2(NUM_VC),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [VC_W-1:0]         in_vc,
    input  logic [FLIT_W-1:0]       in_flit,
    output logic                    out_valid,
    output logic [VC_W-1:0]         out_vc,
    output logic [FLIT_W-1:0]       out_flit,
    input  logic                    out_ready,
    output logic                    crd_rtn_valid,
    output logic [VC_W-1:0]         crd_rtn_vc,
    output logic [NUM_VC*CNT_W-1:0] occupancy,
    output logic                    err_overflow
`ifdef COH_NOC_VCBUF_HWM_EN
    ,
    output logic [NUM_VC*CNT_W-1:0] hwm
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [FLIT_W-1:0] mem [NUM_VC][DEPTH];

    logic [CNT_W-1:0] count_q  [NUM_VC];
    logic [CNT_W-1:0] count_d  [NUM_VC];
    logic [PTR_W-1:0] wr_ptr_q [NUM_VC];
    logic [PTR_W-1:0] wr_ptr_d [NUM_VC];
    logic [PTR_W-1:0] rd_ptr_q [NUM_VC];
    logic [PTR_W-1:0] rd_ptr_d [NUM_VC];
    logic [VC_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [VC_W-1:0]  lock_vc_q, lock_vc_d;
    logic             lock_q, lock_d;
    logic             crd_vld_q, crd_vld_d;
    logic [VC_W-1:0]  crd_vc_q, crd_vc_d;
    logic             err_q, err_d;

    logic             any_vld;
    logic [VC_W-1:0]  search_vc;
    logic [VC_W-1:0]  grant;
    logic             pop;
    logic             vc_ok;
    logic             wr_ok;
    logic [31:0]      in_vc_ext;

    // Descending scan so the VC closest to rr_ptr wins.
    always_comb begin
        any_vld   = 1'b0;
        search_vc = '0;
        for (int i = NUM_VC - 1; i >= 0; i--) begin
            if (count_q[(int'(rr_ptr_q) + i) % NUM_VC] != '0) begin
                any_vld   = 1'b1;
                search_vc = VC_W'((int'(rr_ptr_q) + i) % NUM_VC);
            end
        end
    end

    assign grant     = lock_q ? lock_vc_q : search_vc;
    assign out_valid = any_vld;
    assign out_vc    = grant;
    assign out_flit  = mem[grant][rd_ptr_q[grant]];
    assign pop       = out_valid && out_ready;

    // Fullness uses the pre-cycle count, so a same-cycle pop never rescues a write to a full VC.
    assign in_vc_ext = 32'(in_vc);
    assign vc_ok     = in_vc_ext < NUM_VC;
    assign wr_ok     = in_valid && vc_ok && (count_q[in_vc] != CNT_W'(DEPTH));

    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            count_d[v]  = count_q[v];
            wr_ptr_d[v] = wr_ptr_q[v];
            rd_ptr_d[v] = rd_ptr_q[v];
            if (wr_ok && in_vc == VC_W'(v)) begin
                wr_ptr_d[v] = wr_ptr_q[v] + 1'b1;
                count_d[v]  = count_d[v] + 1'b1;
            end
            if (pop && grant == VC_W'(v)) begin
                rd_ptr_d[v] = rd_ptr_q[v] + 1'b1;
                count_d[v]  = count_d[v] - 1'b1;
            end
        end

        rr_ptr_d  = rr_ptr_q;
        lock_d    = lock_q;
        lock_vc_d = lock_vc_q;
        if (pop) begin
            rr_ptr_d = VC_W'((int'(grant) + 1) % NUM_VC);
            lock_d   = 1'b0;
        end else if (out_valid) begin
            lock_d    = 1'b1;
            lock_vc_d = grant;
        end

        crd_vld_d = pop;
        crd_vc_d  = pop ? grant : '0;
        err_d     = err_q | (in_valid && !wr_ok);
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[in_vc][wr_ptr_q[in_vc]] <= in_flit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '{default: '0};
            wr_ptr_q  <= '{default: '0};
            rd_ptr_q  <= '{default: '0};
            rr_ptr_q  <= '0;
            lock_q    <= 1'b0;
            lock_vc_q <= '0;
            crd_vld_q <= 1'b0;
            crd_vc_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rr_ptr_q  <= rr_ptr_d;
            lock_q    <= lock_d;
            lock_vc_q <= lock_vc_d;
            crd_vld_q <= crd_vld_d;
            crd_vc_q  <= crd_vc_d;
            err_q     <= err_d;
        end
    end

    assign crd_rtn_valid = crd_vld_q;
    assign crd_rtn_vc    = crd_vc_q;
    assign err_overflow  = err_q;

    always_comb begin
        occupancy = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            occupancy[v*CNT_W +: CNT_W] = count_q[v];
        end
    end

`ifdef COH_NOC_VCBUF_HWM_EN
    logic [CNT_W-1:0] hwm_q [NUM_VC];
    logic [CNT_W-1:0] hwm_d [NUM_VC];

    always_comb begin
        hwm = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            hwm_d[v] = (count_q[v] > hwm_q[v]) ? count_q[v] : hwm_q[v];
            hwm[v*CNT_W +: CNT_W] = hwm_q[v];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hwm_q <= '{default: '0};
        end else begin
            hwm_q <= hwm_d;
        end
    end
`endif

endmodule

// File: tb/tb_coh_noc_vc_input_buffer.sv
// Bench for coh_noc_vc_input_buffer: directed scenarios then random traffic, checked against a queue-based model.
module tb_coh_noc_vc_input_buffer;

    localparam int NUM_VC = 4;
    localparam int DEPTH  = 16;
    localparam int FLIT_W = 128;
    localparam int VC_W   = 2;
    localparam int CNT_W  = 5;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic [VC_W-1:0]         in_vc;
    logic [FLIT_W-1:0]       in_flit;
    logic                    out_valid;
    logic [VC_W-1:0]         out_vc;
    logic [FLIT_W-1:0]       out_flit;
    logic                    out_ready;
    logic                    crd_rtn_valid;
    logic [VC_W-1:0]         crd_rtn_vc;
    logic [NUM_VC*CNT_W-1:0] occupancy;
    logic                    err_overflow;
`ifdef COH_NOC_VCBUF_HWM_EN
    logic [NUM_VC*CNT_W-1:0] hwm;
`endif

    always #5 clk = ~clk;

    coh_noc_vc_input_buffer #(.NUM_VC(NUM_VC), .DEPTH(DEPTH), .FLIT_W(FLIT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_vc         (in_vc),
        .in_flit       (in_flit),
        .out_valid     (out_valid),
        .out_vc        (out_vc),
        .out_flit      (out_flit),
        .out_ready     (out_ready),
        .crd_rtn_valid (crd_rtn_valid),
        .crd_rtn_vc    (crd_rtn_vc),
        .occupancy     (occupancy),
        .err_overflow  (err_overflow)
`ifdef COH_NOC_VCBUF_HWM_EN
        ,
        .hwm           (hwm)
`endif
    );

    // Reference model: one queue per VC plus arbitration bookkeeping.
    logic [FLIT_W-1:0] mq [NUM_VC][$];
    int  m_rr;
    bit  m_lock;
    int  m_lock_vc;
    bit  m_crd;
    int  m_crd_vc;
    bit  m_err;
    int  m_hwm [NUM_VC];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_grant();
        if (m_lock) return m_lock_vc;
        for (int i = 0; i < NUM_VC; i++) begin
            if (mq[(m_rr + i) % NUM_VC].size() > 0) return (m_rr + i) % NUM_VC;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < NUM_VC; v++) begin
            mq[v].delete();
            m_hwm[v] = 0;
        end
        m_rr = 0; m_lock = 0; m_lock_vc = 0; m_crd = 0; m_crd_vc = 0; m_err = 0;
    endtask

    function automatic logic [NUM_VC*CNT_W-1:0] exp_occ();
        logic [NUM_VC*CNT_W-1:0] e;
        e = '0;
        for (int v = 0; v < NUM_VC; v++) e[v*CNT_W +: CNT_W] = CNT_W'(mq[v].size());
        return e;
    endfunction

    task automatic cycle(input bit vld, input int vc, input logic [FLIT_W-1:0] f, input bit rdy);
        int g;
        bit full;
        @(negedge clk);
        in_valid  = vld;
        in_vc     = VC_W'(vc);
        in_flit   = f;
        out_ready = rdy;
        #1;
        g = m_grant();
        chk("out_valid", 128'(out_valid), 128'(g >= 0));
        if (g >= 0) begin
            chk("out_vc", 128'(out_vc), 128'(g));
            chk("out_flit", out_flit, mq[g][0]);
        end
        chk("crd_rtn_valid", 128'(crd_rtn_valid), 128'(m_crd));
        chk("crd_rtn_vc", 128'(crd_rtn_vc), 128'(m_crd_vc));
        chk("occupancy", 128'(occupancy), 128'(exp_occ()));
        chk("err_overflow", 128'(err_overflow), 128'(m_err));
`ifdef COH_NOC_VCBUF_HWM_EN
        begin
            logic [NUM_VC*CNT_W-1:0] eh;
            for (int v = 0; v < NUM_VC; v++) eh[v*CNT_W +: CNT_W] = CNT_W'(m_hwm[v]);
            chk("hwm", 128'(hwm), 128'(eh));
        end
`endif
        // Next-state of the model, using the occupancy seen before this edge.
        for (int v = 0; v < NUM_VC; v++)
            if (mq[v].size() > m_hwm[v]) m_hwm[v] = mq[v].size();
        full     = vld && (mq[vc].size() == DEPTH);
        m_crd    = 0;
        m_crd_vc = 0;
        if (g >= 0 && rdy) begin
            void'(mq[g].pop_front());
            m_crd    = 1;
            m_crd_vc = g;
            m_rr     = (g + 1) % NUM_VC;
            m_lock   = 0;
        end else if (g >= 0) begin
            m_lock    = 1;
            m_lock_vc = g;
        end
        if (vld) begin
            if (full) m_err = 1;
            else      mq[vc].push_back(f);
        end
    endtask

    // Asynchronous assertion away from any clock edge; outputs must drop at once.
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_crd_valid", 128'(crd_rtn_valid), 128'(0));
        chk("rst_crd_vc", 128'(crd_rtn_vc), 128'(0));
        chk("rst_occupancy", 128'(occupancy), 128'(0));
        chk("rst_err", 128'(err_overflow), 128'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [FLIT_W-1:0] rnd_flit();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_vc = '0; in_flit = '0; out_ready = 1'b0;
        model_reset();
        do_reset();

        // Single flit to VC2: presented next cycle, credit the cycle after.
        cycle(1, 2, 128'hA5, 1);
        cycle(0, 0, '0, 1);
        cycle(0, 0, '0, 1);
        cycle(0, 0, '0, 1);

        // Two flits per VC, then drain in round-robin order.
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int v = 0; v < NUM_VC; v++) cycle(1, v, rnd_flit(), 0);
        for (int i = 0; i < 10; i++) cycle(0, 0, '0, 1);

        // VC1 stalled while VC0 fills: grant must stay on VC1.
        cycle(1, 1, rnd_flit(), 0);
        for (int i = 0; i < 5; i++) cycle(1, 0, rnd_flit(), 0);
        for (int i = 0; i < 8; i++) cycle(0, 0, '0, 1);

        // Fill VC3 to DEPTH, one extra write overflows; drain across pointer wrap.
        for (int i = 0; i < DEPTH + 1; i++) cycle(1, 3, rnd_flit(), 0);
        chk("occ_vc3_full", 128'(occupancy[3*CNT_W +: CNT_W]), 128'(DEPTH));
        for (int i = 0; i < DEPTH + 2; i++) cycle(0, 0, '0, 1);
        chk("err_sticky", 128'(err_overflow), 128'(1));

        // Simultaneous write and pop on VC0 at count 5, then reset mid-traffic.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1, 0, rnd_flit(), 0);
        cycle(1, 0, rnd_flit(), 1);
        cycle(0, 0, '0, 0);
        chk("occ_vc0_five", 128'(occupancy[0 +: CNT_W]), 128'(5));
        cycle(1, 1, rnd_flit(), 1);
        cycle(1, 2, rnd_flit(), 1);
        do_reset();

        // VC1 reaches 7 then drains; high-water mark holds at 7.
        for (int i = 0; i < 7; i++) cycle(1, 1, rnd_flit(), 0);
        for (int i = 0; i < 9; i++) cycle(0, 0, '0, 1);
`ifdef COH_NOC_VCBUF_HWM_EN
        chk("hwm_vc1", 128'(hwm[CNT_W +: CNT_W]), 128'(7));
`endif

        // Random traffic, including bursts that overflow.
        for (int i = 0; i < 800; i++)
            cycle($urandom_range(0, 99) < 65, int'($urandom_range(0, NUM_VC - 1)),
                  rnd_flit(), $urandom_range(0, 99) < 50);
        for (int i = 0; i < NUM_VC * DEPTH + 4; i++) cycle(0, 0, '0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
